// File: rtl/conv_ctrl_pkg.sv
// Shared types and default parameters for the multi-channel convolution controller.
package conv_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE        = 4'd0,
      ST_LOAD_COEFF  = 4'd1,
      ST_WAIT_COEFF  = 4'd2,
      ST_LOAD_SAMPLE = 4'd3,
      ST_WAIT_SAMPLE = 4'd4,
      ST_START_CONV  = 4'd5,
      ST_WAIT_CONV   = 4'd6,
      ST_RESULT      = 4'd7,
      ST_SHIFT       = 4'd8
   } state_t;

   localparam int unsigned DEF_NUM_CH       = 4;
   localparam int unsigned DEF_CNT_W        = 16;
   localparam int unsigned DEF_CONV_TIMEOUT = 255;

endpackage

// File: rtl/conv_timeout_counter.sv
// Counts cycles spent waiting on a convolution; expired is high on the
// CONV_TIMEOUT-th enabled cycle after a clear.
module conv_timeout_counter
   import conv_ctrl_pkg::*;
#(
   parameter int unsigned CONV_TIMEOUT = DEF_CONV_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned    TW    = $clog2(CONV_TIMEOUT + 1);
   localparam logic [TW-1:0] LIMIT = TW'(CONV_TIMEOUT - 1);

   logic [TW-1:0] cnt;

   assign expired = enable && (cnt == LIMIT);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (enable && !expired) begin
         cnt <= cnt + TW'(1);
      end
   end

endmodule

// File: rtl/multi_conv_controller.sv
// Sequencer for NUM_CH convolution channels sharing one sample stream:
// coefficient load, sample load, per-channel conv/result handshake and shift.
module multi_conv_controller
   import conv_ctrl_pkg::*;
#(
   parameter int unsigned NUM_CH       = DEF_NUM_CH,
   parameter int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int unsigned CNT_W        = DEF_CNT_W,
   parameter int unsigned CONV_TIMEOUT = DEF_CONV_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             conv_en,
   input  logic             cont_mode,
   input  logic             coeff_loaded,
   input  logic             sample_loaded,
   input  logic             conv_complete,
   input  logic             sample_complete,
   input  logic             result_ack,
   output logic             load_coeff,
   output logic             load_sample,
   output logic             start_conv,
   output logic             shift,
   output logic             result_ready,
   output logic [CH_W-1:0]  ch_sel,
   output logic [CNT_W-1:0] sample_cnt,
   output logic             busy,
   output logic             timeout_err
);

   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   state_t           state, state_nx;
   logic [CH_W-1:0]  ch_nx;
   logic [CNT_W-1:0] cnt_nx;
   logic             err_nx;
   logic             eos, eos_nx;
   logic             in_conv;
   logic             to_expired;

   assign in_conv = (state == ST_START_CONV) || (state == ST_WAIT_CONV);

   conv_timeout_counter #(
      .CONV_TIMEOUT(CONV_TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (!in_conv),
      .enable  (in_conv),
      .expired (to_expired)
   );

   // Pulse and wait states share one arm: a done input seen in the pulse
   // cycle skips the wait state entirely.
   always_comb begin
      state_nx = state;
      ch_nx    = ch_sel;
      cnt_nx   = sample_cnt;
      err_nx   = timeout_err;
      case (state)
         ST_IDLE: begin
            if (conv_en) begin
               state_nx = ST_LOAD_COEFF;
               ch_nx    = '0;
               cnt_nx   = '0;
               err_nx   = 1'b0;
            end
         end
         ST_LOAD_COEFF, ST_WAIT_COEFF: begin
            if (coeff_loaded) begin
               if (ch_sel != LAST_CH) begin
                  ch_nx    = ch_sel + CH_W'(1);
                  state_nx = ST_LOAD_COEFF;
               end else begin
                  ch_nx    = '0;
                  state_nx = ST_LOAD_SAMPLE;
               end
            end else if (state == ST_LOAD_COEFF) begin
               state_nx = ST_WAIT_COEFF;
            end
         end
         ST_LOAD_SAMPLE, ST_WAIT_SAMPLE: begin
            if (sample_loaded) begin
               state_nx = ST_START_CONV;
            end else if (state == ST_LOAD_SAMPLE) begin
               state_nx = ST_WAIT_SAMPLE;
            end
         end
         ST_START_CONV, ST_WAIT_CONV: begin
            if (conv_complete) begin
               state_nx = ST_RESULT;
            end else if (to_expired) begin
               state_nx = ST_IDLE;
               ch_nx    = '0;
               err_nx   = 1'b1;
            end else if (state == ST_START_CONV) begin
               state_nx = ST_WAIT_CONV;
            end
         end
         ST_RESULT: begin
            if (result_ack) begin
               if (ch_sel != LAST_CH) begin
                  ch_nx    = ch_sel + CH_W'(1);
                  state_nx = ST_START_CONV;
               end else begin
                  state_nx = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            cnt_nx = sample_cnt + CNT_W'(1);
            ch_nx  = '0;
            if (!eos) begin
               state_nx = ST_LOAD_SAMPLE;
            end else if (cont_mode) begin
               state_nx = ST_LOAD_COEFF;
               cnt_nx   = '0;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         default: begin
            state_nx = ST_IDLE;
            ch_nx    = '0;
         end
      endcase

      // Abort overrides every transition above but keeps count and error.
      if ((state != ST_IDLE) && !conv_en) begin
         state_nx = ST_IDLE;
         ch_nx    = '0;
         cnt_nx   = sample_cnt;
         err_nx   = timeout_err;
      end

      eos_nx = eos || ((state != ST_IDLE) && sample_complete);
      if (state_nx == ST_LOAD_SAMPLE) begin
         eos_nx = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         ch_sel      <= '0;
         sample_cnt  <= '0;
         timeout_err <= 1'b0;
         eos         <= 1'b0;
      end else begin
         state       <= state_nx;
         ch_sel      <= ch_nx;
         sample_cnt  <= cnt_nx;
         timeout_err <= err_nx;
         eos         <= eos_nx;
      end
   end

   assign load_coeff   = (state == ST_LOAD_COEFF);
   assign load_sample  = (state == ST_LOAD_SAMPLE);
   assign start_conv   = (state == ST_START_CONV);
   assign shift        = (state == ST_SHIFT);
   assign result_ready = (state == ST_RESULT);
   assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_multi_conv_controller.sv
// Directed bench for multi_conv_controller with NUM_CH=2 and CONV_TIMEOUT=8;
// a responder answers each request one cycle later.
module tb_multi_conv_controller;

   logic        tb_clk;
   logic        rst;
   logic        conv_en;
   logic        cont_mode;
   logic        coeff_loaded;
   logic        sample_loaded;
   logic        conv_complete;
   logic        sample_complete;
   logic        result_ack;
   logic        load_coeff;
   logic        load_sample;
   logic        start_conv;
   logic        shift;
   logic        result_ready;
   logic [0:0]  ch_sel;
   logic [15:0] sample_cnt;
   logic        busy;
   logic        timeout_err;

   int n_assert = 0;
   int n_fail   = 0;
   int n_lc = 0, n_ls_p = 0, n_sc = 0, n_rr = 0, n_sh = 0;
   int n_ls   = 0;
   int eos_at = 0;
   int blk_ch = -1;
   logic cc_en = 1'b1;

   multi_conv_controller #(
      .NUM_CH       (2),
      .CNT_W        (16),
      .CONV_TIMEOUT (8)
   ) dut (
      .clk             (tb_clk),
      .rst             (rst),
      .conv_en         (conv_en),
      .cont_mode       (cont_mode),
      .coeff_loaded    (coeff_loaded),
      .sample_loaded   (sample_loaded),
      .conv_complete   (conv_complete),
      .sample_complete (sample_complete),
      .result_ack      (result_ack),
      .load_coeff      (load_coeff),
      .load_sample     (load_sample),
      .start_conv      (start_conv),
      .shift           (shift),
      .result_ready    (result_ready),
      .ch_sel          (ch_sel),
      .sample_cnt      (sample_cnt),
      .busy            (busy),
      .timeout_err     (timeout_err)
   );

   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   // Cycle counts of each output, accumulated over the whole run.
   always @(posedge tb_clk) begin
      if (load_coeff)   n_lc++;
      if (load_sample)  n_ls_p++;
      if (start_conv)   n_sc++;
      if (result_ready) n_rr++;
      if (shift)        n_sh++;
   end

   task automatic tick();
      @(posedge tb_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_in();
      coeff_loaded    = 1'b0;
      sample_loaded   = 1'b0;
      conv_complete   = 1'b0;
      sample_complete = 1'b0;
      result_ack      = 1'b0;
   endtask

   task automatic auto_step();
      logic p_lc, p_ls, p_sc;
      p_lc = load_coeff;
      p_ls = load_sample;
      p_sc = start_conv;
      tick();
      coeff_loaded    = p_lc;
      sample_loaded   = p_ls;
      conv_complete   = p_sc && cc_en;
      sample_complete = p_ls && (n_ls == eos_at);
      result_ack      = (int'(ch_sel) != blk_ch);
      if (load_sample) n_ls++;
   endtask

   initial begin
      int steps;
      int b_lc, b_ls, b_sc, b_rr, b_sh;

      rst = 1'b1; conv_en = 1'b0; cont_mode = 1'b0;
      clr_in();
      tick(); tick();
      check("rst_busy", busy, 1'b0);
      check("rst_pulses", {load_coeff, load_sample, start_conv, shift, result_ready}, 5'b0);
      check("rst_ch", ch_sel, 1'b0);
      check("rst_cnt", sample_cnt, 16'd0);
      check("rst_err", timeout_err, 1'b0);
      rst = 1'b0;
      tick();

      // Normal run: 3 samples, end of stream on the third.
      b_lc = n_lc; b_ls = n_ls_p; b_sc = n_sc; b_rr = n_rr; b_sh = n_sh;
      n_ls = 0; eos_at = 3; blk_ch = -1; cc_en = 1'b1;
      conv_en = 1'b1;
      tick();
      check("start_lc", load_coeff, 1'b1);
      check("start_ch", ch_sel, 1'b0);
      steps = 1;
      for (int i = 0; i < 80; i++) begin
         auto_step();
         steps++;
         if (!busy) break;
      end
      conv_en = 1'b0;
      clr_in();
      check("norm_idle", busy, 1'b0);
      check("norm_len", steps, 32);
      check("norm_lc", n_lc - b_lc, 2);
      check("norm_ls", n_ls_p - b_ls, 3);
      check("norm_sc", n_sc - b_sc, 6);
      check("norm_rr", n_rr - b_rr, 6);
      check("norm_sh", n_sh - b_sh, 3);
      check("norm_cnt", sample_cnt, 16'd3);
      check("norm_err", timeout_err, 1'b0);
      tick();
      check("norm_stay", busy, 1'b0);

      // Backpressure on channel 1 for 10 cycles.
      n_ls = 0; eos_at = 1; blk_ch = 1;
      conv_en = 1'b1;
      for (int i = 0; i < 60 && !(result_ready && ch_sel == 1'b1); i++) auto_step();
      for (int k = 0; k < 10; k++) begin
         check("bp_rr", result_ready, 1'b1);
         check("bp_ch", ch_sel, 1'b1);
         check("bp_nosc", start_conv, 1'b0);
         if (k < 9) auto_step();
      end
      blk_ch = -1;
      result_ack = 1'b1;
      auto_step();
      check("bp_shift", shift, 1'b1);
      auto_step();
      check("bp_idle", busy, 1'b0);
      check("bp_cnt", sample_cnt, 16'd1);
      conv_en = 1'b0;
      clr_in();
      tick();

      // Timeout: conv_complete withheld.
      n_ls = 0; eos_at = 0; cc_en = 1'b0;
      conv_en = 1'b1;
      for (int i = 0; i < 40 && !start_conv; i++) auto_step();
      check("to_start", start_conv, 1'b1);
      for (int k = 1; k < 8; k++) begin
         auto_step();
         check("to_busy", busy, 1'b1);
         check("to_noerr", timeout_err, 1'b0);
      end
      auto_step();
      check("to_idle", busy, 1'b0);
      check("to_err", timeout_err, 1'b1);
      check("to_ch", ch_sel, 1'b0);
      conv_en = 1'b0;
      clr_in();
      tick();
      check("to_sticky", timeout_err, 1'b1);
      conv_en = 1'b1;
      tick();
      check("to_clear", timeout_err, 1'b0);
      check("to_relc", load_coeff, 1'b1);
      conv_en = 1'b0;
      tick();
      check("abort_lc", busy, 1'b0);

      // Continuous mode: end of stream on sample 2 restarts the frame.
      n_ls = 0; eos_at = 2; cc_en = 1'b1; cont_mode = 1'b1;
      conv_en = 1'b1;
      for (int i = 0; i < 80 && !(shift && n_ls == 2); i++) auto_step();
      check("cm_shift", shift, 1'b1);
      check("cm_cnt_pre", sample_cnt, 16'd1);
      auto_step();
      check("cm_lc", load_coeff, 1'b1);
      check("cm_ch", ch_sel, 1'b0);
      check("cm_cnt", sample_cnt, 16'd0);

      // Abort during WAIT_SAMPLE of the second sample of the new frame.
      for (int i = 0; i < 60 && !(load_sample && sample_cnt == 16'd1); i++) auto_step();
      check("ab_ls", load_sample, 1'b1);
      clr_in();
      tick();
      check("ab_wait", busy, 1'b1);
      check("ab_nols", load_sample, 1'b0);
      conv_en = 1'b0;
      sample_loaded = 1'b1;
      tick();
      check("ab_idle", busy, 1'b0);
      check("ab_ch", ch_sel, 1'b0);
      check("ab_cnt", sample_cnt, 16'd1);
      b_lc = n_lc; b_ls = n_ls_p; b_sc = n_sc; b_sh = n_sh;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("ab_quiet", {load_coeff, load_sample, start_conv, shift, result_ready}, 5'b0);
      end
      check("ab_nopulse", (n_lc - b_lc) + (n_ls_p - b_ls) + (n_sc - b_sc) + (n_sh - b_sh), 0);
      check("ab_cnt_hold", sample_cnt, 16'd1);
      cont_mode = 1'b0;
      clr_in();

      // Reset for 2 cycles in the middle of WAIT_CONV on channel 1.
      n_ls = 0; eos_at = 0; cc_en = 1'b1;
      conv_en = 1'b1;
      for (int i = 0; i < 40 && !(start_conv && ch_sel == 1'b1); i++) auto_step();
      cc_en = 1'b0;
      auto_step();
      check("mr_wait", busy, 1'b1);
      check("mr_ch", ch_sel, 1'b1);
      clr_in();
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         check("mr_busy", busy, 1'b0);
         check("mr_pulses", {load_coeff, load_sample, start_conv, shift, result_ready}, 5'b0);
         check("mr_ch0", ch_sel, 1'b0);
         check("mr_cnt", sample_cnt, 16'd0);
         check("mr_err", timeout_err, 1'b0);
      end
      rst = 1'b0;
      conv_en = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_conv_controller.md
# multi_conv_controller

Parametrised successor to the single-channel convolution controller. It sequences coefficient loading, sample loading, convolution start, result hand-off and shift for NUM_CH convolution channels that share one sample stream. It adds a result backpressure handshake, a continuous-frame mode, a sample counter and a convolution-timeout error. It sits between the host control interface and the per-channel coefficient, sample and MAC datapath.

## Interface
- NUM_CH, 4: number of convolution channels (≥1).
- CH_W, $clog2(NUM_CH) (min 1): derived, channel index width.
- CNT_W, 16: sample counter width.
- CONV_TIMEOUT, 255: max cycles to wait for conv_complete (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- conv_en  in  1  run enable; low aborts any operation.
- cont_mode  in  1  1 = restart the frame (reload coefficients) after end of stream; 0 = stop.
- coeff_loaded  in  1  coefficient bank ch_sel loaded.
- sample_loaded  in  1  new sample in shared sample register.
- conv_complete  in  1  channel ch_sel finished its convolution.
- sample_complete  in  1  current sample is the last of the stream.
- result_ack  in  1  consumer accepted the result.
- load_coeff  out  1  one-cycle request: load coefficients for ch_sel.
- load_sample  out  1  one-cycle request: load the next sample.
- start_conv  out  1  one-cycle start for channel ch_sel.
- shift  out  1  one-cycle shift of the sample window.
- result_ready  out  1  result of ch_sel valid; held until acked.
- ch_sel  out  CH_W  active channel index.
- sample_cnt  out  CNT_W  samples fully processed this frame.
- busy  out  1  state ≠ IDLE.
- timeout_err  out  1  sticky conv_complete timeout flag.

## Operation
- States: IDLE, LOAD_COEFF, WAIT_COEFF, LOAD_SAMPLE, WAIT_SAMPLE, START_CONV, WAIT_CONV, RESULT, SHIFT.
- Outputs are Moore, decoded from the registered state. Reset: all outputs 0, ch_sel=0, sample_cnt=0, state IDLE.
- IDLE: conv_en=1 → LOAD_COEFF with ch_sel=0, timeout_err cleared, sample_cnt cleared.
- LOAD_COEFF (load_coeff=1, one cycle) → WAIT_COEFF. A done input completes the step in either the pulse state or the wait state. If coeff_loaded is already high in LOAD_COEFF, skip WAIT_COEFF.
- On coeff_loaded: if ch_sel<NUM_CH-1, ch_sel++ and → LOAD_COEFF. Otherwise ch_sel=0 and → LOAD_SAMPLE.
- LOAD_SAMPLE/WAIT_SAMPLE: same pattern with load_sample and sample_loaded → START_CONV.
- sample_complete is latched into a sticky eos flag whenever high in any non-IDLE state. The flag is cleared on entry to LOAD_SAMPLE.
- START_CONV (start_conv=1, one cycle) → WAIT_CONV. conv_complete in either state → RESULT.
- RESULT: result_ready=1 holds until result_ack.
  - On ack with ch_sel<NUM_CH-1: ch_sel++ and → START_CONV.
  - On ack with the last channel: → SHIFT.
- SHIFT (shift=1, one cycle): sample_cnt++ (wraps modulo 2^CNT_W), ch_sel=0.
  - eos=0 → LOAD_SAMPLE.
  - eos=1 with cont_mode=1 → LOAD_COEFF (sample_cnt cleared).
  - eos=1 with cont_mode=0 → IDLE.
- Timeout: a counter runs in START_CONV/WAIT_CONV. When it reaches CONV_TIMEOUT without conv_complete, timeout_err is set and the state goes to IDLE. conv_complete on the timeout cycle wins (no error).
- Abort: conv_en=0 in any non-IDLE state → IDLE on the next edge.
  - Abort overrides every other transition.
  - sample_cnt and timeout_err are preserved.
  - ch_sel is reset to 0.
- Done inputs are ignored in states that do not wait on them.

## Timing
- conv_en sampled 1 at edge N in IDLE → load_coeff high for the cycle after edge N.
- Minimum per-sample time with all done/ack inputs high on first cycle: 1 (LOAD_SAMPLE) + NUM_CH×(START_CONV + RESULT) + 1 (SHIFT) = 2·NUM_CH+2 cycles.
- Pulse outputs are never high for 2 consecutive cycles on the same ch_sel.
- rst takes priority over everything, including mid-handshake. Outputs are 0 in the cycle after the reset edge.

## Structure
- Package conv_ctrl_pkg holds:
  - the state typedef enum logic [3:0];
  - default parameter constants.
- Sub-module conv_timeout_counter (parameter CONV_TIMEOUT):
  - inputs: clk, rst, clear, enable;
  - output: expired.
- The FSM, channel index and sample counter live in the top module.

## Test plan
- Reset: assert rst for 2 cycles mid-WAIT_CONV → all outputs 0, busy=0, ch_sel=0 the next cycle.
- Normal, NUM_CH=2, all done inputs respond 1 cycle after request, ack immediately, 3 samples, sample_complete on the 3rd, cont_mode=0 → exactly 2 load_coeff, 3 load_sample, 6 start_conv and 6 result_ready pulses, 3 shift; sample_cnt=3; return to IDLE.
- Backpressure: hold result_ack low 10 cycles on ch 1 → result_ready stays high 10 cycles with ch_sel=1, no start_conv meanwhile.
- Timeout, CONV_TIMEOUT=8: withhold conv_complete → timeout_err=1 after 8 cycles, IDLE. Re-enabling conv_en clears the flag.
- Continuous mode: cont_mode=1, sample_complete on sample 2 → load_coeff for ch 0 follows the shift; sample_cnt reads 0.
- Abort: drop conv_en during WAIT_SAMPLE → IDLE next edge, no further pulses, sample_cnt unchanged.
